clk_div_gen: RTL and testbench

CLK_DIV_GEN -- requirements
Module: clk_div_gen

---
 rtl/clk_div_gen.sv | 117 +++++++++++
 tb/tb_clk_div_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_gen
//  Purpose  : NUM_CH independent programmable clock dividers. Each channel
//             emits a registered divided clock, a one-cycle enable pulse on
//             the first high cycle of every period, and a lock flag.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_gen #(
  parameter int NUM_CH   = 2,
  parameter int DIV_W    = 8,
  parameter int DIV_INIT = 4
) (
  input  logic                    clkin,
  input  logic                    reset,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       clkout,
  output logic [NUM_CH-1:0]       clken,
  output logic [NUM_CH-1:0]       lock
);

  // Divisor in force after reset, with the minimum-of-two clamp folded in
  localparam logic [DIV_W-1:0] c_div_rst = (DIV_INIT < 2) ? DIV_W'(2) : DIV_W'(DIV_INIT);
  localparam logic [DIV_W-1:0] c_one     = DIV_W'(1);
  localparam logic [DIV_W-1:0] c_two     = DIV_W'(2);
  localparam logic [DIV_W:0]   c_one_w   = (DIV_W+1)'(1);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_seen;
    logic             r_clkout;
    logic             r_clken;
    logic             r_lock;

    logic [DIV_W-1:0] w_val;
    logic [DIV_W-1:0] w_pend_clamp;
    logic [DIV_W-1:0] w_cnt_next;
    logic [DIV_W:0]   w_half;
    logic             w_wrap;
    logic             w_apply;
    logic             w_clk_next;

    // Next-phase decode: wrap detection, pending-apply decision and the high/low split
    always_comb begin
      w_val        = div_val[gi*DIV_W +: DIV_W];
      w_pend_clamp = (r_pend_div < c_two) ? c_two : r_pend_div;
      w_wrap       = (r_cnt == (r_div - c_one));
      // A pending divisor takes over at a period boundary, or at once while idle
      w_apply      = r_pend && (w_wrap || !ch_en[gi]);
      w_cnt_next   = w_wrap ? '0 : (r_cnt + c_one);
      // High phase is ceil(D/2) cycles; phase 0 is always high for D >= 2
      w_half       = ({1'b0, r_div} + c_one_w) >> 1;
      w_clk_next   = ({1'b0, w_cnt_next} < w_half);
    end

    // Phase counter, divisor bookkeeping and registered outputs for this channel
    always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
        r_cnt      <= c_div_rst - c_one;
        r_div      <= c_div_rst;
        r_pend_div <= c_div_rst;
        r_pend     <= 1'b0;
        r_seen     <= 1'b0;
        r_clkout   <= 1'b0;
        r_clken    <= 1'b0;
        r_lock     <= 1'b0;
      end else begin
        if (ch_en[gi]) begin
          r_cnt    <= w_cnt_next;
          r_clkout <= w_clk_next;
          r_clken  <= w_wrap;
          if (w_wrap) begin
            // First period start after enable or a divisor change only arms lock
            if (w_apply || !r_seen) begin
              r_seen <= 1'b1;
              r_lock <= 1'b0;
            end else begin
              r_lock <= !div_load[gi];
            end
          end else if (div_load[gi]) begin
            r_lock <= 1'b0;
          end
        end else begin
          // Park one step before wrap so re-enable starts a fresh period
          r_cnt    <= w_apply ? (w_pend_clamp - c_one) : (r_div - c_one);
          r_clkout <= 1'b0;
          r_clken  <= 1'b0;
          r_lock   <= 1'b0;
          r_seen   <= 1'b0;
        end

        if (w_apply) begin
          r_div <= w_pend_clamp;
        end

        // A new load always wins over clearing the flag for the value just applied
        if (div_load[gi]) begin
          r_pend     <= 1'b1;
          r_pend_div <= w_val;
        end else if (w_apply) begin
          r_pend <= 1'b0;
        end
      end
    end

    assign clkout[gi] = r_clkout;
    assign clken[gi]  = r_clken;
    assign lock[gi]   = r_lock;
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div_gen
//  Purpose  : Directed self-checking bench for clk_div_gen with a period-level
//             reference model and hand-computed waveform windows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_gen;
  localparam int NUM_CH   = 2;
  localparam int DIV_W    = 8;
  localparam int DIV_INIT = 4;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NUM_CH*DIV_W-1:0] div_val = '0;
  logic [NUM_CH-1:0]       div_load = '0;
  logic [NUM_CH-1:0]       ch_en = '1;
  logic [NUM_CH-1:0]       clkout;
  logic [NUM_CH-1:0]       clken;
  logic [NUM_CH-1:0]       lock;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] rc_o0, rc_e0, rc_l0, rc_o1, rc_e1, rc_l1;

  // Reference model state: period length, position in period (-1 = idle),
  // pending divisor, and number of period starts since enable/apply.
  int m_d      [NUM_CH];
  int m_pos    [NUM_CH];
  int m_pv     [NUM_CH];
  int m_starts [NUM_CH];
  bit m_pend   [NUM_CH];
  logic [NUM_CH-1:0] e_out = '0;
  logic [NUM_CH-1:0] e_en  = '0;
  logic [NUM_CH-1:0] e_lk  = '0;

  clk_div_gen #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .DIV_INIT(DIV_INIT)
  ) dut (
    .clkin   (clk),
    .reset   (reset),
    .div_val (div_val),
    .div_load(div_load),
    .ch_en   (ch_en),
    .clkout  (clkout),
    .clken   (clken),
    .lock    (lock)
  );

  always #5 clk = ~clk;

  function automatic int clampd(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic record(input int n);
    rc_o0 = '0; rc_e0 = '0; rc_l0 = '0;
    rc_o1 = '0; rc_e1 = '0; rc_l1 = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rc_o0 = {rc_o0[30:0], clkout[0]};
      rc_e0 = {rc_e0[30:0], clken[0]};
      rc_l0 = {rc_l0[30:0], lock[0]};
      rc_o1 = {rc_o1[30:0], clkout[1]};
      rc_e1 = {rc_e1[30:0], clken[1]};
      rc_l1 = {rc_l1[30:0], lock[1]};
    end
  endtask

  task automatic load_pulse(input logic [NUM_CH-1:0] m, input logic [NUM_CH*DIV_W-1:0] v);
    div_val  = v;
    div_load = m;
    @(negedge clk);
    div_load = '0;
  endtask

  // Reference model: advances one clock per rising edge, period by period
  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      m_d[c] = clampd(DIV_INIT); m_pos[c] = -1; m_pv[c] = 0; m_starts[c] = 0; m_pend[c] = 0;
    end
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int c = 0; c < NUM_CH; c++) begin
          m_d[c] = clampd(DIV_INIT); m_pos[c] = -1; m_starts[c] = 0; m_pend[c] = 0;
        end
        e_out = '0; e_en = '0; e_lk = '0;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_en[c]) begin
            if (m_pos[c] < 0 || m_pos[c] == m_d[c] - 1) begin
              if (m_pend[c]) begin
                m_d[c] = clampd(m_pv[c]);
                m_pend[c] = 0;
                m_starts[c] = 0;
              end
              m_pos[c] = 0;
              if (m_starts[c] < 2) m_starts[c]++;
            end else begin
              m_pos[c]++;
            end
            e_out[c] = (m_pos[c] < (m_d[c] + 1) / 2);
            e_en[c]  = (m_pos[c] == 0);
          end else begin
            m_pos[c] = -1;
            m_starts[c] = 0;
            e_out[c] = 1'b0;
            e_en[c]  = 1'b0;
          end
          if (div_load[c]) begin
            m_pend[c] = 1;
            m_pv[c]   = int'(div_val[c*DIV_W +: DIV_W]);
          end
          e_lk[c] = ch_en[c] && (m_starts[c] >= 2) && !m_pend[c];
        end
      end
    end
  end

  // Cycle-by-cycle comparison of the DUT against the model
  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("model_clkout", 32'(clkout), 32'(e_out));
      chk("model_clken",  32'(clken),  32'(e_en));
      chk("model_lock",   32'(lock),   32'(e_lk));
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Power-up: period 4 on both channels, lock at the second clken
    record(9);
    chk("rst_clkout0", rc_o0, 9'b110011001);
    chk("rst_clken0",  rc_e0, 9'b100010001);
    chk("rst_lock0",   rc_l0, 9'b000011111);

    // Load 5 on ch0 mid-period; takes over at the next boundary
    load_pulse(2'b01, 16'h0005);
    chk("load_lock_clr", 32'(lock[0]), 32'd0);
    record(13);
    chk("d5_clkout0", rc_o0, 13'b0011100111001);
    chk("d5_clken0",  rc_e0, 13'b0010000100001);
    chk("d5_lock0",   rc_l0, 13'b0000000111111);
    chk("d5_clkout1", rc_o1, 13'b0011001100110);

    // Load 0 clamps to 2
    load_pulse(2'b01, 16'h0000);
    record(9);
    chk("d0_clkout0", rc_o0, 9'b100101010);
    chk("d0_clken0",  rc_e0, 9'b000101010);
    chk("d0_lock0",   rc_l0, 9'b000001111);

    // Load 1 on a boundary cycle: applies one boundary later
    load_pulse(2'b01, 16'h0001);
    chk("d1_lock_clr", 32'(lock[0]), 32'd0);
    record(8);
    chk("d1_clkout0", rc_o0, 8'b01010101);
    chk("d1_clken0",  rc_e0, 8'b01010101);
    chk("d1_lock0",   rc_l0, 8'b00011111);

    // ch1 at cnt=1 loads 6, then at cnt=2 loads 8 (last wins)
    div_val  = 16'h0600;
    div_load = 2'b10;
    @(negedge clk);
    chk("ow_lock1", 32'(lock[1]), 32'd0);
    div_val  = 16'h0800;
    @(negedge clk);
    div_load = '0;
    record(10);
    chk("d8_clkout1", rc_o1, 10'b1111000011);
    chk("d8_clken1",  rc_e1, 10'b1000000010);
    chk("d8_lock1",   rc_l1, 10'b0000000011);

    // Drop ch0 during a high phase, load 3 while idle, re-enable
    ch_en = 2'b10;
    record(1);
    chk("dis_clkout0", rc_o0, 32'd0);
    load_pulse(2'b01, 16'h0003);
    record(1);
    chk("idle_clkout0", rc_o0, 32'd0);
    chk("idle_lock0",   rc_l0, 32'd0);
    ch_en = 2'b11;
    record(4);
    chk("ren_clkout0", rc_o0, 4'b1101);
    chk("ren_clken0",  rc_e0, 4'b1001);
    chk("ren_lock0",   rc_l0, 4'b0001);

    // Reset with a pending load of 10: outputs clear at once, period 4 after
    load_pulse(2'b01, 16'h000A);
    reset = 1'b1;
    #1;
    chk("arst_clkout", 32'(clkout), 32'd0);
    chk("arst_clken",  32'(clken),  32'd0);
    chk("arst_lock",   32'(lock),   32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    record(8);
    chk("post_clkout0", rc_o0, 8'b11001100);
    chk("post_clken0",  rc_e0, 8'b10001000);
    chk("post_lock0",   rc_l0, 8'b00001111);
    chk("post_clkout1", rc_o1, 8'b11001100);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
